// File: rtl/multiplier_dispatch.sv
// rtl/multiplier_dispatch.sv - operand FIFO and start/collect sequencer for an iterative multiplier
//
// multiplier_dispatch_fifo : operand-pair queue (DEPTH power of two, WIDTH bits per entry)
// multiplier_dispatch      : top level
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand-pair push handshake, in_a/in_b 32-bit unsigned
//   m_valid_in, m_a, m_b  one-cycle start pulse and held operands to the multiplier
//   m_valid_out, m_r      multiplier completion and 64-bit product
//   out_valid/out_ready   result handshake, out_r registered product
//   busy                  sequencer not in IDLE
//   error                 sticky WAIT watchdog flag (MULT_DISPATCH_TIMEOUT_EN)
// Optional feature macro: MULT_DISPATCH_TIMEOUT_EN enables the WAIT watchdog.

module multiplier_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign pop_data = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module multiplier_dispatch #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        m_valid_in,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  input  logic [63:0] m_r,
  input  logic        m_valid_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_r,
  output logic        busy,
  output logic        error
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

  state_t      state_q, state_d;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [63:0] fifo_head;
  logic        load_result;
  logic        timeout_hit;

  // in_ready comes from the registered count only, never from this cycle's pop.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign busy      = (state_q != ST_IDLE);

  multiplier_dispatch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

`ifdef MULT_DISPATCH_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_cnt_q;
  logic           error_q;
`endif

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    m_valid_in  = 1'b0;
    load_result = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_valid_in = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_valid_out) begin
          load_result = 1'b1;
          state_d     = ST_HOLD;
        end
`ifdef MULT_DISPATCH_TIMEOUT_EN
        // Last WAIT cycle of the budget with no completion: drop the operation.
        else if (wd_cnt_q == WD_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
`endif
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands load only on pop, so they stay put through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_a       <= '0;
      m_b       <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fifo_pop) {m_a, m_b} <= fifo_head;
      if (load_result) begin
        out_r     <= m_r;
        out_valid <= 1'b1;
      end else if (state_q == ST_HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_DISPATCH_TIMEOUT_EN
  // Counter is cleared during ISSUE so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)     wd_cnt_q <= '0;
      else if (state_q == ST_WAIT) wd_cnt_q <= wd_cnt_q + 1'b1;
      if (timeout_hit) error_q <= 1'b1;
    end
  end
  assign error = error_q;
`else
  // Watchdog not built; the timeout parameter only appears here to keep it referenced.
  assign error = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: tb/tb_multiplier_dispatch.sv
// tb/tb_multiplier_dispatch.sv - directed self-checking bench for multiplier_dispatch
module tb_multiplier_dispatch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        m_valid_in;
  logic [31:0] m_a, m_b;
  logic [63:0] m_r = '0;
  logic        m_valid_out = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_r;
  logic        busy;
  logic        error;

  int total = 0;
  int bad = 0;

  logic [63:0] got [$];
  int          issue_cnt = 0;
  int          mcnt = 0;
  int          lat = 3;
  bit          mult_en = 1'b1;
  logic [31:0] pa = '0, pb = '0;

  multiplier_dispatch #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .m_valid_in  (m_valid_in),
    .m_a         (m_a),
    .m_b         (m_b),
    .m_r         (m_r),
    .m_valid_out (m_valid_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Iterative multiplier stand-in: result 'lat' cycles after the start pulse.
  always @(negedge clk) begin
    m_valid_out = 1'b0;
    if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        m_valid_out = 1'b1;
        m_r = {32'b0, pa} * {32'b0, pb};
      end
    end
    if (m_valid_in && mult_en) begin
      pa = m_a;
      pb = m_b;
      mcnt = lat;
    end
  end

  // Collect accepted results and start pulses mid low phase.
  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) got.push_back(out_r);
    if (m_valid_in) issue_cnt = issue_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total = total + 1;
    if (obs !== exp_v) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got.size() < n && k < 200) begin
      tick();
      k++;
    end
    check("result_count", 64'(got.size()), 64'(n));
  endtask

  task automatic wait_issue();
    int k = 0;
    while (!m_valid_in && k < 20) begin
      tick();
      k++;
    end
    check("issue_seen", 64'(m_valid_in), 64'd1);
  endtask

  logic [31:0] fa [5] = '{32'd1, 32'd7, 32'd100, 32'h0001_0000, 32'h8000_0000};
  logic [31:0] fb [5] = '{32'd2, 32'd6, 32'd1000, 32'h0001_0000, 32'd3};
  logic [63:0] fr [5] = '{64'd2, 64'd42, 64'd100000, 64'h1_0000_0000, 64'h1_8000_0000};

  initial begin
    int base;
    int k;
    int stable;
    logic [63:0] r0;
    logic ov, bz;

    @(negedge clk);
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_m_valid_in", 64'(m_valid_in), 64'd0);
    check("rst_m_a", 64'(m_a), 64'd0);
    check("rst_m_b", 64'(m_b), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_r", out_r, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    tick();

    // Single operation
    out_ready = 1'b1;
    base = issue_cnt;
    push(32'd3, 32'd5);
    wait_issue();
    check("op1_m_a", 64'(m_a), 64'd3);
    check("op1_m_b", 64'(m_b), 64'd5);
    wait_results(1);
    check("op1_result", got[0], 64'd15);
    check("op1_issue_pulses", 64'(issue_cnt - base), 64'd1);
    check("op1_busy_after", 64'(busy), 64'd0);

    // Maximum operands
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_results(2);
    check("max_result", got[1], 64'hFFFF_FFFE_0000_0001);

    // Fill with five back-to-back pairs while the consumer stalls
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = fa[i];
      in_b = fb[i];
      check("fill_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_a = 32'd9;
    in_b = 32'd9;
    check("full_ready", 64'(in_ready), 64'd0);
    k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    check("hold_out_valid", 64'(out_valid), 64'd1);
    r0 = out_r;
    check("hold_first_result", r0, fr[0]);
    base = issue_cnt;
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1 && out_r === r0 && in_ready === 1'b0) stable++;
    end
    check("backpressure_stable", 64'(stable), 64'd20);
    check("backpressure_no_issue", 64'(issue_cnt - base), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_results(7);
    for (int i = 0; i < 5; i++) check("fill_order", got[2+i], fr[i]);
    repeat (20) tick();
    check("fill_none_extra", 64'(got.size()), 64'd7);
    check("fill_issue_total", 64'(issue_cnt), 64'd7);

    // Reset while waiting on the multiplier; its late result must be ignored
    lat = 10;
    base = got.size();
    push(32'd11, 32'd13);
    wait_issue();
    tick();
    tick();
    check("wait_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ov = 1'b0;
    bz = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ov = ov | out_valid;
      bz = bz | busy;
    end
    check("late_out_valid", 64'(ov), 64'd0);
    check("late_busy", 64'(bz), 64'd0);
    check("late_in_ready", 64'(in_ready), 64'd1);
    check("late_out_r", out_r, 64'd0);
    check("late_results", 64'(got.size()), 64'(base));
    lat = 3;

    // Multiplier that never answers
    mult_en = 1'b0;
    push(32'd2, 32'd2);
    wait_issue();
`ifdef MULT_DISPATCH_TIMEOUT_EN
    k = 0;
    while (!error && k < 100) begin
      tick();
      k++;
    end
    check("wd_cycles", 64'(k), 64'd17);
    check("wd_error", 64'(error), 64'd1);
    check("wd_busy", 64'(busy), 64'd0);
    repeat (5) tick();
    check("wd_sticky", 64'(error), 64'd1);
`else
    repeat (40) tick();
    check("nowd_busy", 64'(busy), 64'd1);
    check("nowd_error", 64'(error), 64'd0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("final_error", 64'(error), 64'd0);
    check("final_busy", 64'(busy), 64'd0);
    mult_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
